// File: rtl/wb_burst_sram.sv
// Wishbone SRAM slave: single-beat classic cycles, with optional registered-feedback bursts.
// Define WB_SRAM_BURST_EN to build the BURST state, beat address counter, wrap logic and prefetch.
module wb_burst_sram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30,
    parameter int MEM_AW     = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   wishbone_adr,
    input  logic [DATA_WIDTH-1:0]   wishbone_dat_w,
    output logic [DATA_WIDTH-1:0]   wishbone_dat_r,
    input  logic [DATA_WIDTH/8-1:0] wishbone_sel,
    input  logic                    wishbone_cyc,
    input  logic                    wishbone_stb,
    input  logic                    wishbone_we,
    input  logic [2:0]              wishbone_cti,
    input  logic [1:0]              wishbone_bte,
    output logic                    wishbone_ack,
    output logic                    wishbone_err
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << MEM_AW;

    typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

    state_t                state;
    logic                  beat_rdy;
    logic                  err_q;
    logic                  req;
    logic                  wr_en;
    logic [MEM_AW-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> MEM_AW) == '0;
    endfunction

    // ack follows stb combinationally so a master wait state drops it in the same cycle
    assign req          = wishbone_cyc & wishbone_stb;
    assign wishbone_ack = beat_rdy & req;
    assign wishbone_err = err_q;
    assign wr_en        = wishbone_ack & wishbone_we;

`ifdef WB_SRAM_BURST_EN
    logic [ADDR_WIDTH-1:0] ctr;
    logic [ADDR_WIDTH-1:0] ctr_nxt;
    logic                  start_burst;

    assign start_burst = (wishbone_cti == 3'b001) || (wishbone_cti == 3'b010);
    assign wr_addr     = (state == BURST) ? ctr[MEM_AW-1:0] : wishbone_adr[MEM_AW-1:0];

    always_comb begin
        ctr_nxt = ctr;
        if (wishbone_cti == 3'b010) begin
            case (wishbone_bte)
                2'b00:   ctr_nxt      = ctr + ADDR_WIDTH'(1);
                2'b01:   ctr_nxt[1:0] = ctr[1:0] + 2'd1;
                2'b10:   ctr_nxt[2:0] = ctr[2:0] + 3'd1;
                default: ctr_nxt[3:0] = ctr[3:0] + 4'd1;
            endcase
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{wishbone_cti, wishbone_bte};
    assign wr_addr    = wishbone_adr[MEM_AW-1:0];
`endif

    // No reset on the array: contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wishbone_sel[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wishbone_dat_w[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            beat_rdy       <= 1'b0;
            err_q          <= 1'b0;
            wishbone_dat_r <= '0;
`ifdef WB_SRAM_BURST_EN
            ctr            <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    beat_rdy <= 1'b0;
                    // err_q blocks the still-asserted stb of the errored request from retriggering
                    if (req && !err_q) begin
                        if (!in_range(wishbone_adr)) begin
                            err_q          <= 1'b1;
                            wishbone_dat_r <= '0;
                        end else begin
                            wishbone_dat_r <= mem[wishbone_adr[MEM_AW-1:0]];
                            beat_rdy       <= 1'b1;
`ifdef WB_SRAM_BURST_EN
                            ctr   <= wishbone_adr;
                            state <= start_burst ? BURST : CLASSIC;
`else
                            state <= CLASSIC;
`endif
                        end
                    end
                end
                CLASSIC: begin
                    state    <= IDLE;
                    beat_rdy <= 1'b0;
                end
`ifdef WB_SRAM_BURST_EN
                BURST: begin
                    if (!wishbone_cyc) begin
                        state    <= IDLE;
                        beat_rdy <= 1'b0;
                    end else if (wishbone_stb) begin
                        if (wishbone_cti == 3'b111) begin
                            state    <= IDLE;
                            beat_rdy <= 1'b0;
                        end else if (!in_range(ctr_nxt)) begin
                            state          <= IDLE;
                            beat_rdy       <= 1'b0;
                            err_q          <= 1'b1;
                            wishbone_dat_r <= '0;
                        end else begin
                            ctr            <= ctr_nxt;
                            wishbone_dat_r <= mem[ctr_nxt[MEM_AW-1:0]];
                        end
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    beat_rdy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_burst_sram.sv
// Directed bench for wb_burst_sram: classic vector table plus hand-written burst, abort and reset sequences.
// Burst sequences run when WB_SRAM_BURST_EN is defined; otherwise cti is checked to be ignored.
module tb_wb_burst_sram;
    logic        clk;
    logic        reset;
    logic [29:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vq[$];

    wb_burst_sram dut (
        .clk           (clk),
        .reset         (reset),
        .wishbone_adr  (adr),
        .wishbone_dat_w(dat_w),
        .wishbone_dat_r(dat_r),
        .wishbone_sel  (sel),
        .wishbone_cyc  (cyc),
        .wishbone_stb  (stb),
        .wishbone_we   (we),
        .wishbone_cti  (cti),
        .wishbone_bte  (bte),
        .wishbone_ack  (ack),
        .wishbone_err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic w, input logic [29:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic ea, input logic ee, input logic [31:0] ed);
        vec_t v;
        v.name = nm; v.we = w; v.adr = a; v.dat = d; v.sel = s;
        v.exp_ack = ea; v.exp_err = ee; v.exp_dat = ed;
        vq.push_back(v);
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
    endtask

    // Request cycle (no ack), response cycle, then one cycle after release
    task automatic classic(input vec_t v);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr; dat_w = v.dat; sel = v.sel;
        cti = 3'b000; bte = 2'b00;
        @(negedge clk);
        check({v.name, " req_ack"}, ack, 1'b0);
        check({v.name, " req_err"}, err, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check({v.name, " ack"}, ack, v.exp_ack);
        check({v.name, " err"}, err, v.exp_err);
        if (!v.we || v.exp_err) check({v.name, " dat_r"}, dat_r, v.exp_dat);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check({v.name, " post_ack"}, ack, 1'b0);
        check({v.name, " post_err"}, err, 1'b0);
    endtask

    task automatic do_wr(input string nm, input logic [29:0] a, input logic [31:0] d);
        vec_t v;
        v.name = nm; v.we = 1'b1; v.adr = a; v.dat = d; v.sel = 4'hF;
        v.exp_ack = 1'b1; v.exp_err = 1'b0; v.exp_dat = '0;
        classic(v);
    endtask

    task automatic do_rd(input string nm, input logic [29:0] a, input logic [31:0] d);
        vec_t v;
        v.name = nm; v.we = 1'b0; v.adr = a; v.dat = '0; v.sel = 4'hF;
        v.exp_ack = 1'b1; v.exp_err = 1'b0; v.exp_dat = d;
        classic(v);
    endtask

    initial begin
        int wseq[4];
        wseq[0] = 6; wseq[1] = 7; wseq[2] = 4; wseq[3] = 5;

        add_vec("wr5_full",   1'b1, 30'd5,          32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0);
        add_vec("rd5",        1'b0, 30'd5,          32'h0,        4'hF, 1'b1, 1'b0, 32'hDEADBEEF);
        add_vec("wr5_byte0",  1'b1, 30'd5,          32'h000000AA, 4'h1, 1'b1, 1'b0, 32'h0);
        add_vec("rd5_sel0",   1'b0, 30'd5,          32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEAA);
        add_vec("wr9_zero",   1'b1, 30'd9,          32'h00000000, 4'hF, 1'b1, 1'b0, 32'h0);
        add_vec("wr9_mid",    1'b1, 30'd9,          32'hA1B2C3D4, 4'h6, 1'b1, 1'b0, 32'h0);
        add_vec("rd9",        1'b0, 30'd9,          32'h0,        4'hF, 1'b1, 1'b0, 32'h00B2C300);
        add_vec("wr0",        1'b1, 30'd0,          32'h12345678, 4'hF, 1'b1, 1'b0, 32'h0);
        add_vec("rd0",        1'b0, 30'd0,          32'h0,        4'hF, 1'b1, 1'b0, 32'h12345678);
        add_vec("rd400_oor",  1'b0, 30'h400,        32'h0,        4'hF, 1'b0, 1'b1, 32'h0);
        add_vec("wr400_oor",  1'b1, 30'h400,        32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 32'h0);
        add_vec("rd0_alias",  1'b0, 30'd0,          32'h0,        4'hF, 1'b1, 1'b0, 32'h12345678);
        add_vec("wr3ff",      1'b1, 30'h3FF,        32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h0);
        add_vec("rd3ff",      1'b0, 30'h3FF,        32'h0,        4'hF, 1'b1, 1'b0, 32'hCAFEF00D);
        add_vec("rd_top_oor", 1'b0, 30'h3FFFFFFF,   32'h0,        4'hF, 1'b0, 1'b1, 32'h0);

        bus_idle();
        adr = '0; dat_w = '0; sel = 4'hF;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ack", ack, 1'b0);
        check("reset err", err, 1'b0);
        check("reset dat_r", dat_r, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        foreach (vq[i]) classic(vq[i]);

        // Master abandons a classic write in its response cycle
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'd0; dat_w = 32'hBADBAD00; sel = 4'hF;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("cyc_drop ack", ack, 1'b0);
        @(posedge clk); #1;
        bus_idle();
        do_rd("cyc_drop rd0", 30'd0, 32'h12345678);

        // Reset asserted while a write is being acked
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'd5; dat_w = 32'h55555555; sel = 4'hF;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst ack_before", ack, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("midrst ack", ack, 1'b0);
        check("midrst dat_r", dat_r, 32'h0);
        @(posedge clk); #1;
        bus_idle();
        @(posedge clk); #1;
        reset = 1'b1;
        do_rd("midrst rd5", 30'd5, 32'hDEADBEAA);

`ifdef WB_SRAM_BURST_EN
        // Wrap-4 read burst from 6
        for (int i = 4; i < 8; i++) do_wr("wrap preload", 30'(i), 32'h40000000 | 32'(i));
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'd6; cti = 3'b010; bte = 2'b01;
        @(negedge clk);
        check("wrap req_ack", ack, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            adr = 30'(wseq[k]);
            cti = (k == 3) ? 3'b111 : 3'b010;
            @(negedge clk);
            check($sformatf("wrap beat%0d ack", k), ack, 1'b1);
            check($sformatf("wrap beat%0d dat_r", k), dat_r, 32'h40000000 | 32'(wseq[k]));
        end
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("wrap end ack", ack, 1'b0);

        // Linear write burst 0..7 with two wait states after the third beat
        do_wr("lin preload8", 30'd8, 32'h88888888);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'd0; dat_w = 32'hB0000000; sel = 4'hF;
        cti = 3'b010; bte = 2'b00;
        @(negedge clk);
        check("lin req_ack", ack, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                for (int w = 0; w < 2; w++) begin
                    @(posedge clk); #1;
                    stb = 1'b0; dat_w = 32'hFFFFFFFF;
                    @(negedge clk);
                    check($sformatf("lin wait%0d ack", w), ack, 1'b0);
                end
            end
            @(posedge clk); #1;
            stb = 1'b1; adr = 30'(k); dat_w = 32'hB0000000 | 32'(k);
            cti = (k == 7) ? 3'b111 : 3'b010;
            @(negedge clk);
            check($sformatf("lin beat%0d ack", k), ack, 1'b1);
        end
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("lin end ack", ack, 1'b0);
        for (int k = 0; k < 8; k++) do_rd($sformatf("lin rd%0d", k), 30'(k), 32'hB0000000 | 32'(k));
        do_rd("lin rd8", 30'd8, 32'h88888888);

        // 8-beat write burst abandoned after two beats
        for (int i = 16; i < 20; i++) do_wr("abort preload", 30'(i), 32'hC0000000 | 32'(i));
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'd16; dat_w = 32'hE0000010; sel = 4'hF;
        cti = 3'b010; bte = 2'b00;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            adr = 30'(16 + k); dat_w = 32'hE0000010 | 32'(k);
            @(negedge clk);
            check($sformatf("abort beat%0d ack", k), ack, 1'b1);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; dat_w = 32'hE0000012;
        @(negedge clk);
        check("abort drop ack", ack, 1'b0);
        @(posedge clk); #1;
        bus_idle();
        do_rd("abort rd16", 30'd16, 32'hE0000010);
        do_rd("abort rd17", 30'd17, 32'hE0000011);
        do_rd("abort rd18", 30'd18, 32'hC0000012);
        do_rd("abort rd19", 30'd19, 32'hC0000013);

        // Linear read burst running off the top of memory
        do_wr("edge preload", 30'h3FE, 32'h0BADF00D);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'h3FE; cti = 3'b010; bte = 2'b00;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("edge beat0 dat_r", dat_r, 32'h0BADF00D);
        @(posedge clk); #1;
        adr = 30'h3FF;
        @(negedge clk);
        check("edge beat1 ack", ack, 1'b1);
        check("edge beat1 dat_r", dat_r, 32'hCAFEF00D);
        @(posedge clk); #1;
        adr = 30'h400;
        @(negedge clk);
        check("edge oor ack", ack, 1'b0);
        check("edge oor err", err, 1'b1);
        check("edge oor dat_r", dat_r, 32'h0);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("edge post err", err, 1'b0);
`else
        // cti is ignored: an incrementing-burst request with stb held is still a single classic beat
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'd5; cti = 3'b010; bte = 2'b00;
        @(negedge clk);
        check("nob req_ack", ack, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("nob ack", ack, 1'b1);
        check("nob dat_r", dat_r, 32'hDEADBEAA);
        @(posedge clk); #1;
        @(negedge clk);
        check("nob one_cycle", ack, 1'b0);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("nob drop ack", ack, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_burst_sram.md
WB_BURST_SRAM -- requirements
Module: wb_burst_sram

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 30, meaning the word address bus width.
REQ-003 The block SHALL have parameter MEM_AW, default 10, meaning log2 of the memory depth in words (MEM_AW <= ADDR_WIDTH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port wishbone_adr, input, ADDR_WIDTH bits: word address.
REQ-007 The block SHALL have ports wishbone_dat_w (input) and wishbone_dat_r (output), DATA_WIDTH bits each: write and read data.
REQ-008 The block SHALL have port wishbone_sel, input, DATA_WIDTH/8 bits: byte-lane enables.
REQ-009 The block SHALL have ports wishbone_cyc, wishbone_stb and wishbone_we, input, 1 bit each: cycle, strobe and write enable.
REQ-010 The block SHALL have port wishbone_cti, input, 3 bits, and port wishbone_bte, input, 2 bits: cycle type and burst type.
REQ-011 The block SHALL have ports wishbone_ack and wishbone_err, output, 1 bit each: beat acknowledge and error.

Function
REQ-012 The memory SHALL hold 2**MEM_AW words; an address is in range when wishbone_adr[ADDR_WIDTH-1:MEM_AW] is zero.
REQ-013 The FSM SHALL have three states: IDLE, CLASSIC and BURST.
REQ-014 In IDLE with cyc&stb and an in-range address, the FSM SHALL go to BURST if cti is 001 or 010, and to CLASSIC otherwise.
REQ-015 In CLASSIC, ack SHALL be high for exactly one cycle, starting the cycle after the request; the FSM then SHALL return to IDLE.
REQ-016 Read data SHALL be valid on the same cycle as ack; every access, classic or burst, SHALL have 1-cycle latency.
REQ-017 A write SHALL update only the byte lanes with sel=1, and only on the acked beat; reads SHALL ignore sel.
REQ-018 In BURST, ack SHALL stay high on every cycle that stb is high, one beat per cycle, with the address taken from an internal counter.
REQ-019 The burst counter SHALL be loaded from wishbone_adr on entry and advanced after each acked beat.
REQ-020 With cti=001 the counter SHALL hold the same address on every beat.
REQ-021 With cti=010, bte=00 SHALL increment linearly; 01, 10 and 11 SHALL increment only the low 2, 3 and 4 bits (wrap-4, wrap-8, wrap-16) and keep the upper bits.
REQ-022 The read data for the next burst address SHALL be prefetched so that back-to-back beats need no wait state.
REQ-023 stb low in BURST SHALL deassert ack and hold the counter and the prefetched data (master wait state).
REQ-024 An acked beat with cti=111 SHALL end the burst and return the FSM to IDLE.
REQ-025 cyc low in any state SHALL return the FSM to IDLE in the next cycle, with ack low and no write.
REQ-026 A linear burst that increments past 2**MEM_AW-1 SHALL terminate with err on the out-of-range beat.
REQ-027 An out-of-range request SHALL assert err for one cycle instead of ack, perform no write, and return dat_r as 0.
REQ-028 ack and err SHALL never be high in the same cycle.

Reset
REQ-029 While reset=0, ack, err and dat_r SHALL be 0, the FSM SHALL be IDLE, and the counter SHALL be 0; memory contents SHALL be left unchanged.
REQ-030 Reset asserted mid-burst SHALL drop ack at once, with no further writes; after release the block SHALL accept a new cycle.

Configuration
REQ-031 With WB_SRAM_BURST_EN defined, the block SHALL implement the BURST state, the counter, the wrap logic and prefetch as specified.
REQ-032 Without WB_SRAM_BURST_EN, cti and bte SHALL be ignored, every request SHALL be handled as CLASSIC, and the BURST logic SHALL not be synthesised.

Verification
REQ-033 The bench SHALL cover: classic write 0xDEADBEEF to addr 5 with sel=1111, then classic read of addr 5 -> ack one cycle after stb, dat_r=0xDEADBEEF.
REQ-034 The bench SHALL cover: byte write 0x000000AA to addr 5 with sel=0001 -> a read of addr 5 returns 0xDEADBEAA.
REQ-035 The bench SHALL cover: wrap-4 read burst from addr 6, cti=010 and bte=01, four beats with the last at cti=111 -> addresses 6,7,4,5, ack on four consecutive cycles.
REQ-036 The bench SHALL cover: a linear write burst at addrs 0..7 with stb low for 2 cycles after beat 3 -> ack low in those cycles, all 8 words written, no duplicate.
REQ-037 The bench SHALL cover: a read of addr 0x400 with MEM_AW=10 -> err for one cycle, ack=0, dat_r=0.
REQ-038 The bench SHALL cover: cyc dropped after 2 beats of an 8-beat write burst -> ack low the next cycle, only 2 words changed, and a following classic read succeeds.
